// File: rtl/resp_frame_tx.sv
// Modbus RTU response serializer: latches one of three response vectors and sends it MSB byte first over a tx_start/tx_done byte handshake.
// First tx_start 2 cycles after accept, next byte 2 cycles after each tx_done; waits indefinitely on tx_done, then holds a 3.5-char gap.
module resp_frame_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic         sys_clk,
    input  logic         reset_n,
    input  logic         tx_exp_rp_start,
    input  logic         tx_06_rp_start,
    input  logic         tx_03_04_rp_start,
    input  logic [39:0]  exception_seq,
    input  logic [63:0]  code06_response,
    input  logic [103:0] code03_04_response,
    input  logic         tx_done,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic         tx_busy,
    output logic         frame_done
);

    localparam int GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 35;
    localparam int GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // Last gap count lands frame_done exactly GAP_CYCLES cycles after the final tx_done.
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [103:0]  r_sh, w_sh_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic          r_tx_start, w_tx_start_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_fdone, w_fdone_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_nxt       = r_sh;
        w_cnt_nxt      = r_cnt;
        w_gap_nxt      = r_gap;
        w_busy_nxt     = r_busy;
        w_tx_start_nxt = 1'b0;
        w_fdone_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // No accept in the frame_done cycle itself.
                if (!r_fdone) begin
                    if (tx_exp_rp_start) begin
                        w_sh_nxt    = {exception_seq, 64'h0};
                        w_cnt_nxt   = 4'd5;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SEND;
                    end else if (tx_06_rp_start) begin
                        w_sh_nxt    = {code06_response, 40'h0};
                        w_cnt_nxt   = 4'd8;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SEND;
                    end else if (tx_03_04_rp_start) begin
                        w_sh_nxt    = code03_04_response;
                        w_cnt_nxt   = 4'd13;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                w_tx_start_nxt = 1'b1;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    w_sh_nxt  = {r_sh[95:0], 8'h00};
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt > 4'd1) begin
                        w_state_nxt = S_SEND;
                    end else begin
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_nxt   = '0;
                    w_fdone_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_fdone    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh       <= w_sh_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= w_busy_nxt;
            r_fdone    <= w_fdone_nxt;
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_sh[103:96];
    assign tx_busy    = r_busy;
    assign frame_done = r_fdone;

endmodule

// File: tb/tb_resp_frame_tx.sv
// Bench for resp_frame_tx: table-driven frames, hand-written reset-abort sequence, randomized frames against a byte-list model.
module tb_resp_frame_tx;

    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int GAP = (CF / BR) * 35;

    logic         sys_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tx_exp_rp_start = 1'b0;
    logic         tx_06_rp_start = 1'b0;
    logic         tx_03_04_rp_start = 1'b0;
    logic [39:0]  exception_seq = '0;
    logic [63:0]  code06_response = '0;
    logic [103:0] code03_04_response = '0;
    logic         tx_done = 1'b0;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;
    logic         frame_done;

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int ign_cyc = -1;

    resp_frame_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .sys_clk            (sys_clk),
        .reset_n            (reset_n),
        .tx_exp_rp_start    (tx_exp_rp_start),
        .tx_06_rp_start     (tx_06_rp_start),
        .tx_03_04_rp_start  (tx_03_04_rp_start),
        .exception_seq      (exception_seq),
        .code06_response    (code06_response),
        .code03_04_response (code03_04_response),
        .tx_done            (tx_done),
        .tx_start           (tx_start),
        .tx_data            (tx_data),
        .tx_busy            (tx_busy),
        .frame_done         (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string        name;
        bit           e;
        bit           s6;
        bit           s34;
        logic [39:0]  ve;
        logic [63:0]  v6;
        logic [103:0] v34;
        logic [103:0] want;
        int           n;
        bit           stray;
        bit           ign;
    } vec_t;

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // The 06 line doubles as the "ignored late start" injector.
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        tx_06_rp_start = (cyc == ign_cyc);
    endtask

    function automatic logic [103:0] rnd104();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[103:0];
    endfunction

    // Entered at the sample where tx_start is seen high for this byte.
    task automatic byte_xchg(input string name, input logic [7:0] want, input bit more,
                             input logic [7:0] nxt, input int d);
        chk({name, ".tx_start"}, tx_start, 1);
        chk({name, ".tx_data"}, tx_data, want);
        for (int j = 0; j < d; j++) begin
            tick();
            chk({name, ".start_lo"}, tx_start, 0);
            chk({name, ".data_hold"}, tx_data, want);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({name, ".start_T1"}, tx_start, 0);
        chk({name, ".busy"}, tx_busy, 1);
        if (more) begin
            chk({name, ".data_T1"}, tx_data, nxt);
            tick();
            chk({name, ".start_T2"}, tx_start, 1);
        end
    endtask

    task automatic run_frame(input vec_t v, input int dmax);
        int bad;
        logic [103:0] rest;
        logic [103:0] junk;
        exception_seq      = v.ve;
        code06_response    = v.v6;
        code03_04_response = v.v34;
        tx_exp_rp_start    = v.e;
        tx_06_rp_start     = v.s6;
        tx_03_04_rp_start  = v.s34;
        if (v.ign) ign_cyc = cyc + 10;
        tick();
        tx_exp_rp_start   = 1'b0;
        tx_03_04_rp_start = 1'b0;
        junk = rnd104();
        exception_seq      = junk[39:0];
        code06_response    = junk[63:0];
        code03_04_response = rnd104();
        chk({v.name, ".accept_busy"}, tx_busy, 1);
        chk({v.name, ".accept_start"}, tx_start, 0);
        tick();
        for (int i = 0; i < v.n; i++) begin
            rest = v.want << (8 * (i + 1));
            byte_xchg(v.name, v.want[103 - 8 * i -: 8], i < v.n - 1, rest[103:96],
                      $urandom_range(dmax, 1));
        end
        ign_cyc = -1;
        bad = 0;
        for (int k = 1; k < GAP; k++) begin
            if (tx_start !== 1'b0 || tx_busy !== 1'b1 || frame_done !== 1'b0) bad++;
            if (v.stray && k == 5) begin
                tx_done           = 1'b1;
                tx_03_04_rp_start = 1'b1;
            end
            tick();
            tx_done           = 1'b0;
            tx_03_04_rp_start = 1'b0;
        end
        chk({v.name, ".gap_quiet"}, bad, 0);
        chk({v.name, ".frame_done"}, frame_done, 1);
        chk({v.name, ".busy_end"}, tx_busy, 0);
        if (v.stray) tx_exp_rp_start = 1'b1;
        tick();
        tx_exp_rp_start = 1'b0;
        chk({v.name, ".fd_pulse"}, frame_done, 0);
        chk({v.name, ".idle_busy"}, tx_busy, 0);
        chk({v.name, ".idle_start"}, tx_start, 0);
        tick();
    endtask

    initial begin
        vec_t tbl[6];
        vec_t r;
        int   bad;
        logic [103:0] a;
        logic [103:0] b;
        logic [103:0] c;
        logic [2:0]   p;

        tbl[0] = '{"exc", 1, 0, 0, 40'h01_83_02_C0_F1, 64'h0, 104'h0,
                   {40'h01_83_02_C0_F1, 64'h0}, 5, 0, 0};
        tbl[1] = '{"f06", 0, 1, 0, 40'h0, 64'h01_06_00_01_00_05_18_09, 104'h0,
                   {64'h01_06_00_01_00_05_18_09, 40'h0}, 8, 0, 0};
        tbl[2] = '{"f03", 0, 0, 1, 40'h0, 64'h0, 104'h01_03_08_11_22_33_44_55_66_77_88_A5_5A,
                   104'h01_03_08_11_22_33_44_55_66_77_88_A5_5A, 13, 1, 0};
        tbl[3] = '{"exp_06_pri", 1, 1, 0, 40'h01_83_02_C0_F1, 64'h01_06_00_01_00_05_18_09, 104'h0,
                   {40'h01_83_02_C0_F1, 64'h0}, 5, 0, 1};
        tbl[4] = '{"06_03_pri", 0, 1, 1, 40'h0, 64'h11_06_AB_CD_12_34_56_78,
                   104'hFF_EE_DD_CC_BB_AA_99_88_77_66_55_44_33,
                   {64'h11_06_AB_CD_12_34_56_78, 40'h0}, 8, 0, 0};
        tbl[5] = '{"all_pri", 1, 1, 1, 40'h11_22_33_44_55, 64'h66_77_88_99_AA_BB_CC_DD,
                   104'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D,
                   {40'h11_22_33_44_55, 64'h0}, 5, 1, 0};

        tick();
        chk("rst.tx_start", tx_start, 0);
        chk("rst.tx_data", tx_data, 8'h00);
        chk("rst.tx_busy", tx_busy, 0);
        chk("rst.frame_done", frame_done, 0);
        reset_n = 1'b1;
        tick();
        tick();

        foreach (tbl[i]) run_frame(tbl[i], 3);

        // Reset abort while the third byte of a 06 frame is on the line.
        code06_response = 64'hA1_A2_A3_A4_A5_A6_A7_A8;
        tx_06_rp_start  = 1'b1;
        tick();
        chk("abort.accept_busy", tx_busy, 1);
        tick();
        byte_xchg("abort", 8'hA1, 1, 8'hA2, 2);
        byte_xchg("abort", 8'hA2, 1, 8'hA3, 1);
        chk("abort.byte3", tx_data, 8'hA3);
        reset_n = 1'b0;
        tick();
        chk("abort.tx_start", tx_start, 0);
        chk("abort.tx_data", tx_data, 8'h00);
        chk("abort.tx_busy", tx_busy, 0);
        chk("abort.frame_done", frame_done, 0);
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < GAP + 20; k++) begin
            tick();
            if (frame_done !== 1'b0 || tx_start !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        chk("abort.silent", bad, 0);
        r = tbl[0];
        r.name = "post_abort";
        run_frame(r, 2);

        // Randomized frames: winner by priority, bytes sliced from the winning vector.
        for (int it = 0; it < 10; it++) begin
            a = rnd104();
            b = rnd104();
            c = rnd104();
            p = 3'($urandom_range(7, 1));
            r.name  = $sformatf("rnd%0d", it);
            r.e     = p[2];
            r.s6    = p[1];
            r.s34   = p[0];
            r.ve    = a[39:0];
            r.v6    = b[63:0];
            r.v34   = c;
            r.stray = 1'($urandom_range(1, 0));
            r.ign   = 1'($urandom_range(1, 0));
            if (p[2]) begin
                r.want = {a[39:0], 64'h0};
                r.n    = 5;
            end else if (p[1]) begin
                r.want = {b[63:0], 40'h0};
                r.n    = 8;
            end else begin
                r.want = c;
                r.n    = 13;
            end
            run_frame(r, 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
